// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package prog_loader_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_VERIFY_REQ,
        S_VERIFY_CHK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_LEN    = 2'd1;
    localparam logic [1:0] ERR_CSUM   = 2'd2;
    localparam logic [1:0] ERR_VERIFY = 2'd3;

    localparam int HDR_BYTES = 4;

endpackage

// File: rtl/prog_loader_byte_word_assembler.sv
// Little-endian byte-to-word shift-in; word_next/word_valid flag the 4th byte combinationally.
module prog_loader_byte_word_assembler
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic [31:0] word_next,
    output logic        word_valid
);

    logic [1:0] byte_cnt;

    assign word_next  = {byte_in, word[31:8]};
    assign word_valid = byte_valid && (byte_cnt == 2'(HDR_BYTES - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (byte_valid) begin
            word     <= word_next;
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Loads program memory from a byte stream, verifies it by read-back, then releases the CPU.
//   state        | meaning
//   S_IDLE       | waiting for start
//   S_LEN        | collecting 4-byte word count
//   S_DATA       | collecting one payload word
//   S_WRITE      | writing the assembled word
//   S_CSUM       | comparing the stream checksum byte
//   S_VERIFY_REQ | issuing a read-back
//   S_VERIFY_CHK | accumulating read-back bytes
//   S_DONE       | load verified, CPU released
//   S_ERROR      | load failed, err_code held
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int NUM_BRAMS      = 4,
    parameter int WORDS_PER_BRAM = 2048,
    parameter int BASE_WORD      = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [29:0] mem_address,
    output logic        mem_wen,
    output logic        mem_ren,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_select,
    input  logic [31:0] mem_rdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code
);

    localparam int MAX_WORDS = NUM_BRAMS * WORDS_PER_BRAM;
    localparam int CW        = $clog2(MAX_WORDS) + 1;

    state_t          state_q, state_d;
    logic [CW-1:0]   counter, counter_inc, n_words;
    logic [7:0]      sum, vsum, vsum_next;
    logic [1:0]      err_code_q;
    logic [31:0]     word, word_next, addr_full;
    logic            word_valid, rx_fire, len_bad, last_word;

    assign rx_ready = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
    assign rx_fire  = rx_valid && rx_ready;

    prog_loader_byte_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (state_q == S_IDLE),
        .byte_valid (rx_fire && (state_q == S_LEN || state_q == S_DATA)),
        .byte_in    (rx_data),
        .word       (word),
        .word_next  (word_next),
        .word_valid (word_valid)
    );

    assign len_bad     = (word_next == 32'd0) || (word_next > 32'(MAX_WORDS));
    assign counter_inc = counter + CW'(1);
    assign last_word   = (counter_inc == n_words);
    assign vsum_next   = vsum + mem_rdata[7:0] + mem_rdata[15:8]
                              + mem_rdata[23:16] + mem_rdata[31:24];
    assign addr_full   = 32'(BASE_WORD) + 32'(counter);
    assign mem_address = addr_full[29:0];

    assign busy     = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
    assign done     = (state_q == S_DONE);
    assign error    = (state_q == S_ERROR);
    assign cpu_hold = (state_q != S_DONE);
    assign err_code = err_code_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        mem_wen         = 1'b0;
        mem_ren         = 1'b0;
        mem_wdata       = '0;
        mem_byte_select = '0;
        case (state_q)
            S_IDLE:       if (start) state_d = S_LEN;
            S_LEN:        if (word_valid) state_d = len_bad ? S_ERROR : S_DATA;
            S_DATA:       if (word_valid) state_d = S_WRITE;
            S_WRITE: begin
                mem_wen         = 1'b1;
                mem_wdata       = word;
                mem_byte_select = 4'b1111;
                state_d         = last_word ? S_CSUM : S_DATA;
            end
            S_CSUM:       if (rx_fire) state_d = (rx_data == sum) ? S_VERIFY_REQ : S_ERROR;
            S_VERIFY_REQ: begin
                mem_ren         = 1'b1;
                mem_byte_select = 4'b1111;
                state_d         = S_VERIFY_CHK;
            end
            S_VERIFY_CHK: begin
                if (!last_word)            state_d = S_VERIFY_REQ;
                else if (vsum_next == sum) state_d = S_DONE;
                else                       state_d = S_ERROR;
            end
            S_DONE:       state_d = S_DONE;
            S_ERROR:      state_d = S_ERROR;
            default:      state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            counter    <= '0;
            n_words    <= '0;
            sum        <= '0;
            vsum       <= '0;
            err_code_q <= ERR_NONE;
        end else begin
            case (state_q)
                S_LEN: if (word_valid) begin
                    if (len_bad) begin
                        err_code_q <= ERR_LEN;
                    end else begin
                        n_words <= word_next[CW-1:0];
                        counter <= '0;
                        sum     <= '0;
                    end
                end
                S_DATA:  if (rx_fire) sum <= sum + rx_data;
                S_WRITE: counter <= counter_inc;
                S_CSUM: if (rx_fire) begin
                    if (rx_data != sum) begin
                        err_code_q <= ERR_CSUM;
                    end else begin
                        counter <= '0;
                        vsum    <= '0;
                    end
                end
                S_VERIFY_CHK: begin
                    vsum    <= vsum_next;
                    counter <= counter_inc;
                    if (last_word && vsum_next != sum) err_code_q <= ERR_VERIFY;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected memory accesses are queued, a monitor checks them.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset, start, rx_valid, rx_ready;
    logic [7:0]  rx_data;
    logic [29:0] mem_address;
    logic        mem_wen, mem_ren;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  mem_byte_select;
    logic        cpu_hold, busy, done, error;
    logic [1:0]  err_code;
    logic        corrupt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        is_write;
        logic [29:0] addr;
        logic [31:0] data;
    } acc_t;

    acc_t        exp_q[$];
    acc_t        mon_t;
    logic [31:0] pay[$];
    logic [31:0] mem [0:63];

    always #5 clk = ~clk;

    prog_loader dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .mem_address     (mem_address),
        .mem_wen         (mem_wen),
        .mem_ren         (mem_ren),
        .mem_wdata       (mem_wdata),
        .mem_byte_select (mem_byte_select),
        .mem_rdata       (mem_rdata),
        .cpu_hold        (cpu_hold),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .err_code        (err_code)
    );

    // Memory model; optionally flips bit 0 of word 1 on read-back.
    always @(posedge clk) begin
        if (mem_wen) mem[mem_address[5:0]] <= mem_wdata;
        if (mem_ren) mem_rdata <= mem[mem_address[5:0]] ^
                                  ((corrupt && mem_address == 30'd1) ? 32'h1 : 32'h0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && (mem_wen || mem_ren)) begin
            chk("strobe_overlap", 32'(mem_wen & mem_ren), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_access: wen=%0d ren=%0d addr=%0h, none expected",
                         mem_wen, mem_ren, mem_address);
            end else begin
                mon_t = exp_q.pop_front();
                chk("acc_kind", 32'(mem_wen), 32'(mon_t.is_write));
                chk("acc_addr", 32'(mem_address), 32'(mon_t.addr));
                if (mon_t.is_write) begin
                    chk("wr_data", mem_wdata, mon_t.data);
                    chk("wr_be", 32'(mem_byte_select), 32'hF);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        int t;
        gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        for (int i = 0; i < gap; i++) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        while (!rx_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) begin
            checks++;
            failures++;
            $display("FAIL rx_ready_timeout: byte %0h not accepted", b);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], max_gap);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_writes();
        for (int i = 0; i < pay.size(); i++) exp_q.push_back('{1'b1, 30'(i), pay[i]});
    endtask

    task automatic expect_reads();
        for (int i = 0; i < pay.size(); i++) exp_q.push_back('{1'b0, 30'(i), 32'h0});
    endtask

    task automatic send_payload(input int max_gap);
        for (int i = 0; i < pay.size(); i++) send_word(pay[i], max_gap);
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!(done || error) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!(done || error)) begin
            checks++;
            failures++;
            $display("FAIL end_timeout: neither done nor error after %0d cycles", n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_final(input string tag, input logic e_done, input logic [1:0] e_code);
        chk({tag, "_done"},     32'(done),     32'(e_done));
        chk({tag, "_error"},    32'(error),    32'(!e_done));
        chk({tag, "_err_code"}, 32'(err_code), 32'(e_code));
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!e_done));
        chk({tag, "_busy"},     32'(busy),     32'd0);
        chk({tag, "_pending"},  32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_busy"},     32'(busy),     32'd0);
        chk({tag, "_done"},     32'(done),     32'd0);
        chk({tag, "_error"},    32'(error),    32'd0);
        chk({tag, "_err_code"}, 32'(err_code), 32'd0);
        chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        chk({tag, "_wen_ren"},  32'({mem_wen, mem_ren}), 32'd0);
        chk({tag, "_addr"},     32'(mem_address), 32'd0);
        chk({tag, "_wdata"},    mem_wdata, 32'd0);
        chk({tag, "_be"},       32'(mem_byte_select), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; corrupt = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("por");

        // Payload 11 22 33 44 AA BB CC DD: modular byte sum is 0xB8.
        pay = '{32'h44332211, 32'hDDCCBBAA};
        expect_writes();
        expect_reads();
        pulse_start();
        send_word(32'd2, 0);
        send_payload(0);
        send_byte(8'hB8, 0);
        wait_end();
        check_final("good2", 1'b1, 2'd0);

        do_reset();
        expect_writes();
        pulse_start();
        send_word(32'd2, 0);
        send_payload(0);
        send_byte(8'hB9, 0);
        wait_end();
        check_final("badcsum", 1'b0, 2'd2);

        do_reset();
        pulse_start();
        send_word(32'd0, 0);
        wait_end();
        check_final("len0", 1'b0, 2'd1);

        do_reset();
        pulse_start();
        send_word(32'd8193, 0);
        wait_end();
        check_final("len8193", 1'b0, 2'd1);

        do_reset();
        corrupt = 1'b1;
        expect_writes();
        expect_reads();
        pulse_start();
        send_word(32'd2, 0);
        send_payload(0);
        send_byte(8'hB8, 0);
        wait_end();
        check_final("verify", 1'b0, 2'd3);
        corrupt = 1'b0;

        // 01..08 DE AD BE EF sums to 0x35C -> 0x5C.
        do_reset();
        pay = '{32'h04030201, 32'h08070605, 32'hDEADBEEF};
        expect_writes();
        expect_reads();
        pulse_start();
        send_word(32'd3, 7);
        send_payload(7);
        send_byte(8'h5C, 7);
        wait_end();
        check_final("gaps3", 1'b1, 2'd0);

        do_reset();
        pulse_start();
        send_word(32'd2, 0);
        send_byte(8'h11, 0);
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        reset = 1'b0;
        @(negedge clk);
        pay = '{32'h44332211, 32'hDDCCBBAA};
        expect_writes();
        expect_reads();
        pulse_start();
        send_word(32'd2, 0);
        send_payload(0);
        send_byte(8'hB8, 0);
        wait_end();
        check_final("after_rst", 1'b1, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
